// File: rtl/input_port_requester_if.sv
// Bundle of the FIFO-side, arbiter-side and crossbar-side signals of one router input port.
interface input_port_requester_if #(
    parameter int unsigned OUT_N      = 5,
    parameter int unsigned DATA_WIDTH = 8
);
    localparam int unsigned SelW = $clog2(OUT_N);

    logic [DATA_WIDTH-1:0] flit_i;
    logic                  flit_vld_i;
    logic                  flit_rdy_o;
    logic [OUT_N-1:0]      req_o;
    logic [OUT_N-1:0]      grant_i;
    logic                  out_rdy_i;
    logic [DATA_WIDTH-1:0] flit_o;
    logic                  flit_vld_o;
    logic [SelW-1:0]       out_sel_o;
    logic                  err_o;
    logic [7:0]            pkt_cnt_o;

    // Requester (the input port itself)
    modport slave (
        input  flit_i, flit_vld_i, grant_i, out_rdy_i,
        output flit_rdy_o, req_o, flit_o, flit_vld_o, out_sel_o, err_o, pkt_cnt_o
    );

    // Surroundings: FIFO, output arbiters and crossbar
    modport master (
        output flit_i, flit_vld_i, grant_i, out_rdy_i,
        input  flit_rdy_o, req_o, flit_o, flit_vld_o, out_sel_o, err_o, pkt_cnt_o
    );
endinterface

// File: rtl/input_port_requester.sv
// Input-port requester: XY-routes the head flit, holds a one-hot request to the chosen
// output arbiter for the whole packet and forwards one flit per granted, ready cycle.
module input_port_requester #(
    parameter int unsigned OUT_N      = 5,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned X_W        = 2,
    parameter int unsigned Y_W        = 2,
    parameter int unsigned ROUTER_X   = 0,
    parameter int unsigned ROUTER_Y   = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input_port_requester_if.slave  bus
);
    localparam int unsigned SelW = $clog2(OUT_N);

    localparam logic [SelW-1:0] PortLocal = SelW'(0);
    localparam logic [SelW-1:0] PortNorth = SelW'(1);
    localparam logic [SelW-1:0] PortEast  = SelW'(2);
    localparam logic [SelW-1:0] PortSouth = SelW'(3);
    localparam logic [SelW-1:0] PortWest  = SelW'(4);

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    state_e          state_q, state_d;
    logic [SelW-1:0] out_sel_q, out_sel_d, route_sel;
    logic            first_q, first_d;   // no flit of the current packet has transferred yet
    logic            err_q, err_d;
    logic [7:0]      pkt_cnt_q, pkt_cnt_d;

    logic [1:0]      flit_type;
    logic            is_head, is_tail, granted, fwd_vld, transfer;
    logic [X_W-1:0]  dest_x;
    logic [Y_W-1:0]  dest_y;

    // Type 10 head, 11 single, 00 body, 01 tail: bit 1 marks a head, bit 0 a tail
    assign flit_type = bus.flit_i[DATA_WIDTH-1 -: 2];
    assign is_head   = flit_type[1];
    assign is_tail   = flit_type[0];
    assign dest_x    = bus.flit_i[X_W-1:0];
    assign dest_y    = bus.flit_i[X_W+Y_W-1:X_W];
    assign granted   = bus.grant_i[out_sel_q];

    // XY route of the flit at the FIFO head, X resolved first
    always_comb begin
        route_sel = PortLocal;
        if (dest_x > X_W'(ROUTER_X)) begin
            route_sel = PortEast;
        end else if (dest_x < X_W'(ROUTER_X)) begin
            route_sel = PortWest;
        end else if (dest_y > Y_W'(ROUTER_Y)) begin
            route_sel = PortNorth;
        end else if (dest_y < Y_W'(ROUTER_Y)) begin
            route_sel = PortSouth;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: open a packet on a head, close it when its tail transfers
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (bus.flit_vld_i && is_head) state_d = StActive;
            StActive: if (transfer && is_tail)       state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // FSM outputs: request, forward-valid and FIFO pop
    always_comb begin
        bus.req_o      = '0;
        bus.flit_rdy_o = 1'b0;
        fwd_vld        = 1'b0;
        transfer       = 1'b0;
        unique case (state_q)
            // Stray body/tail is dropped; a head waits in the FIFO until routed
            StIdle: bus.flit_rdy_o = bus.flit_vld_i & ~is_head;
            StActive: begin
                bus.req_o      = OUT_N'(1) << out_sel_q;
                fwd_vld        = bus.flit_vld_i & granted;
                transfer       = fwd_vld & bus.out_rdy_i;
                bus.flit_rdy_o = transfer;
            end
            default: ;
        endcase
    end

    assign bus.flit_vld_o = fwd_vld;
    assign bus.flit_o     = bus.flit_i;
    assign bus.out_sel_o  = out_sel_q;
    assign bus.err_o      = err_q;
    assign bus.pkt_cnt_o  = pkt_cnt_q;

    // Route latch, error pulse and packet counter next state
    always_comb begin
        out_sel_d = out_sel_q;
        first_d   = first_q;
        err_d     = 1'b0;
        pkt_cnt_d = pkt_cnt_q;
        if (state_q == StIdle && bus.flit_vld_i) begin
            if (is_head) begin
                out_sel_d = route_sel;
                first_d   = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
        if (transfer) begin
            first_d = 1'b0;
            // A head inside a packet means the previous tail went missing
            if (is_head && !first_q) err_d = 1'b1;
            if (is_tail) pkt_cnt_d = pkt_cnt_q + 8'd1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_sel_q <= '0;
            first_q   <= 1'b0;
            err_q     <= 1'b0;
            pkt_cnt_q <= '0;
        end else begin
            out_sel_q <= out_sel_d;
            first_q   <= first_d;
            err_q     <= err_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end
endmodule

// File: tb/tb_input_port_requester.sv
module tb_input_port_requester;
    typedef struct {
        bit         drop;
        logic [7:0] flit;
        int         port;
        bit         err;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;
    bit   err_exp = 1'b0;
    ev_t  exp_q[$];
    logic [7:0] stream[$];
    int   model_pkts = 0;

    input_port_requester_if #(.OUT_N(5), .DATA_WIDTH(8)) bus ();

    input_port_requester #(
        .OUT_N(5), .DATA_WIDTH(8), .X_W(2), .Y_W(2), .ROUTER_X(1), .ROUTER_Y(1)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference XY route for router (1,1): 0=L 1=N 2=E 3=S 4=W
    function automatic int route(input logic [7:0] f);
        int x = int'(f[1:0]);
        int y = int'(f[3:2]);
        if (x > 1) return 2;
        if (x < 1) return 4;
        if (y > 1) return 1;
        if (y < 1) return 3;
        return 0;
    endfunction

    // Expected pop sequence from a flit stream: packet-level view of the protocol
    task automatic model_stream();
        bit in_pkt = 1'b0;
        int port = 0;
        foreach (stream[i]) begin
            logic [7:0] f = stream[i];
            ev_t e;
            e.flit = f;
            if (!in_pkt) begin
                if (f[7]) begin
                    port = route(f);
                    in_pkt = 1'b1;
                    e.drop = 1'b0; e.port = port; e.err = 1'b0;
                end else begin
                    e.drop = 1'b1; e.port = 0; e.err = 1'b1;
                end
            end else begin
                e.drop = 1'b0; e.port = port; e.err = f[7];
            end
            if (!e.drop && f[6]) begin
                in_pkt = 1'b0;
                model_pkts++;
            end
            exp_q.push_back(e);
        end
    endtask

    // Monitor: every pop is matched against the scoreboard; err_o checked a cycle later
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            ev_t e;
            chk("err_o", 32'(bus.err_o), 32'(err_exp));
            err_exp = 1'b0;
            chk("flit_vld_o_rule", 32'(bus.flit_vld_o),
                32'((bus.req_o != 0) && bus.flit_vld_i && ((bus.grant_i & bus.req_o) != 0)));
            if (bus.flit_rdy_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", 32'(1), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_kind_fwd", 32'(bus.flit_vld_o), 32'(!e.drop));
                    chk("flit_o", 32'(bus.flit_o), 32'(e.flit));
                    if (!e.drop) begin
                        chk("out_sel_o", 32'(bus.out_sel_o), 32'(e.port));
                        chk("req_o", 32'(bus.req_o), 32'(1) << e.port);
                    end
                    err_exp = e.err;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit pop = 1'b0;
        bit hold = 1'b0;
        int cyc = 0;
        int r;
        bus.flit_i = '0; bus.flit_vld_i = 1'b0; bus.grant_i = '0; bus.out_rdy_i = 1'b0;

        // Reset state
        #12;
        chk("rst_req_o", 32'(bus.req_o), 32'(0));
        chk("rst_flit_rdy_o", 32'(bus.flit_rdy_o), 32'(0));
        chk("rst_flit_vld_o", 32'(bus.flit_vld_o), 32'(0));
        chk("rst_out_sel_o", 32'(bus.out_sel_o), 32'(0));
        chk("rst_err_o", 32'(bus.err_o), 32'(0));
        chk("rst_pkt_cnt_o", 32'(bus.pkt_cnt_o), 32'(0));
        rst_n = 1'b1;

        // Single flit to local, granted and ready: request one cycle after, pop same cycle
        step();
        bus.flit_vld_i = 1'b1; bus.flit_i = 8'hC5; bus.grant_i = 5'b00001; bus.out_rdy_i = 1'b1;
        @(negedge clk);
        chk("single_t_req", 32'(bus.req_o), 32'(0));
        chk("single_t_pop", 32'(bus.flit_rdy_o), 32'(0));
        step();
        @(negedge clk);
        chk("single_t1_req", 32'(bus.req_o), 32'(5'b00001));
        chk("single_t1_pop", 32'(bus.flit_rdy_o), 32'(1));
        step();
        bus.flit_vld_i = 1'b0;
        @(negedge clk);
        chk("single_t2_req", 32'(bus.req_o), 32'(0));
        chk("single_pkt_cnt", 32'(bus.pkt_cnt_o), 32'(1));

        // Stray tail in idle: dropped, one error pulse, counter unchanged
        step();
        bus.flit_vld_i = 1'b1; bus.flit_i = 8'h40;
        @(negedge clk);
        chk("tail_idle_pop", 32'(bus.flit_rdy_o), 32'(1));
        chk("tail_idle_req", 32'(bus.req_o), 32'(0));
        step();
        bus.flit_vld_i = 1'b0;
        @(negedge clk);
        chk("tail_idle_err", 32'(bus.err_o), 32'(1));
        chk("tail_idle_cnt", 32'(bus.pkt_cnt_o), 32'(1));
        @(negedge clk);
        chk("tail_idle_err_once", 32'(bus.err_o), 32'(0));

        // Head to (0,3): WEST; a grant on another output must not forward
        step();
        bus.flit_vld_i = 1'b1; bus.flit_i = 8'h8C;
        step();
        bus.grant_i = 5'b01000; bus.out_rdy_i = 1'b1;
        @(negedge clk);
        chk("west_req", 32'(bus.req_o), 32'(5'b10000));
        chk("wrong_grant_vld", 32'(bus.flit_vld_o), 32'(0));
        chk("wrong_grant_pop", 32'(bus.flit_rdy_o), 32'(0));

        // Asynchronous reset mid-packet drops the request immediately
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_req", 32'(bus.req_o), 32'(0));
        chk("midrst_cnt", 32'(bus.pkt_cnt_o), 32'(0));
        bus.flit_i = 8'hC1; bus.out_rdy_i = 1'b0;
        #1 rst_n = 1'b1;

        // Head to (1,0) re-routed from idle: SOUTH, held until ready rises
        step();
        @(negedge clk);
        chk("south_req", 32'(bus.req_o), 32'(5'b01000));
        chk("south_sel", 32'(bus.out_sel_o), 32'(3));
        chk("stall_vld", 32'(bus.flit_vld_o), 32'(1));
        chk("stall_pop", 32'(bus.flit_rdy_o), 32'(0));
        step();
        bus.out_rdy_i = 1'b1;
        @(negedge clk);
        chk("south_pop", 32'(bus.flit_rdy_o), 32'(1));
        step();
        bus.flit_vld_i = 1'b0;
        @(negedge clk);
        chk("south_done_req", 32'(bus.req_o), 32'(0));
        chk("south_cnt", 32'(bus.pkt_cnt_o), 32'(1));

        // Random packets, stray flits and missing tails against the scoreboard
        for (int p = 0; p < 400; p++) begin
            int len = 1 + int'($urandom_range(3));
            if ($urandom_range(9) == 0) stream.push_back({1'b0, 1'($urandom), 6'($urandom)});
            if (len == 1) begin
                stream.push_back({2'b11, 6'($urandom)});
            end else begin
                stream.push_back({2'b10, 6'($urandom)});
                for (int b = 1; b < len - 1; b++) begin
                    if ($urandom_range(7) == 0) stream.push_back({2'b10, 6'($urandom)});
                    else stream.push_back({2'b00, 6'($urandom)});
                end
                stream.push_back({2'b01, 6'($urandom)});
            end
        end
        model_stream();

        rst_n = 1'b0;
        #3 rst_n = 1'b1;
        err_exp = 1'b0;
        mon_en = 1'b1;
        while (cyc < 40000) begin
            step();
            if (pop) void'(stream.pop_front());
            pop = 1'b0;
            if (stream.size() == 0) break;
            bus.flit_vld_i = hold ? 1'b1 : ($urandom_range(4) != 0);
            bus.flit_i = stream[0];
            r = int'($urandom_range(3));
            if (r == 0) bus.grant_i = '0;
            else if (r == 1) bus.grant_i = 5'(1) << $urandom_range(4);
            else bus.grant_i = bus.req_o;
            bus.out_rdy_i = ($urandom_range(3) != 0);
            @(negedge clk);
            pop = bus.flit_rdy_o;
            hold = bus.flit_vld_i && !pop;
            cyc++;
        end
        bus.flit_vld_i = 1'b0;
        chk("drain_left", 32'(stream.size()), 32'(0));
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));
        chk("pkt_cnt_wrap", 32'(bus.pkt_cnt_o), 32'(model_pkts % 256));
        chk("final_req", 32'(bus.req_o), 32'(0));
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
